// File: rtl/dccm_ctrl_pkg.sv
// Shared types, defaults and the DCCM window range check for the data-memory responder.
package dccm_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DCCM_BASE_DEF = 32'h8000_0000;
    localparam int DCCM_DEPTH_DEF = 16384;

    // State carried by a read from the request cycle into the output stage.
    typedef struct packed {
        logic            valid;
        logic            in_range;
        logic            bypass;
        logic [XLEN-1:0] bypass_data;
    } dccm_req_t;

    // Unsigned window check done one bit wider so the upper bound cannot wrap.
    function automatic logic dccm_in_range(input logic [XLEN-1:0] addr,
                                           input logic [XLEN-1:0] base,
                                           input int unsigned     depth);
        logic [XLEN:0] limit;
        limit = {1'b0, base} + ({1'b0, XLEN'(depth)} << 2);
        return (addr >= base) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/dccm_ctrl_if.sv
// LSU <-> DCCM bus: one read port and one write port, both usable every cycle.
interface dccm_ctrl_if;
    import dccm_ctrl_pkg::*;

    // No ready signal: a request is accepted in any cycle its strobe (rvalid_in or wen)
    // is high; each read yields exactly one rvalid_out pulse two cycles later, in order.
    logic [XLEN-1:0] dccm_raddr;
    logic            dccm_rvalid_in;
    logic [XLEN-1:0] dccm_rdata;
    logic            dccm_rvalid_out;
    logic [XLEN-1:0] dccm_waddr;
    logic            dccm_wen;
    logic [XLEN-1:0] dccm_wdata;
    logic            dccm_err;

    modport master (
        output dccm_raddr, dccm_rvalid_in, dccm_waddr, dccm_wen, dccm_wdata,
        input  dccm_rdata, dccm_rvalid_out, dccm_err
    );

    modport slave (
        input  dccm_raddr, dccm_rvalid_in, dccm_waddr, dccm_wen, dccm_wdata,
        output dccm_rdata, dccm_rvalid_out, dccm_err
    );

endinterface

// File: rtl/dccm_sram.sv
// 1R1W synchronous read-first word array; no reset so it can be swapped for a macro.
module dccm_sram #(
    parameter int DEPTH = 16384,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Same-address collisions return the old word; the controller forwards the new one.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dccm_ctrl.sv
// DCCM responder: window decode, same-cycle write forwarding and a 2-stage read pipe.
module dccm_ctrl
    import dccm_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] DCCM_BASE  = DCCM_BASE_DEF,
    parameter int              DCCM_DEPTH = DCCM_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    dccm_ctrl_if.slave bus
);

    localparam int AW = $clog2(DCCM_DEPTH);

    logic            r_in_range;
    logic            w_in_range;
    logic [AW-1:0]   ridx;
    logic [AW-1:0]   widx;
    logic [XLEN-1:0] sram_q;
    dccm_req_t       r1;
    logic [XLEN-1:0] rdata_q;
    logic            rvalid_q;
    logic            rd_err_q;
    logic            wr_err_q;

    assign r_in_range = dccm_in_range(bus.dccm_raddr, DCCM_BASE, DCCM_DEPTH);
    assign w_in_range = dccm_in_range(bus.dccm_waddr, DCCM_BASE, DCCM_DEPTH);
    assign ridx = bus.dccm_raddr[AW+1:2];
    assign widx = bus.dccm_waddr[AW+1:2];

    dccm_sram #(
        .DEPTH (DCCM_DEPTH),
        .WIDTH (XLEN)
    ) u_sram (
        .clk   (clk),
        .we    (bus.dccm_wen & w_in_range),
        .waddr (widx),
        .wdata (bus.dccm_wdata),
        .re    (bus.dccm_rvalid_in & r_in_range),
        .raddr (ridx),
        .rdata (sram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1       <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rd_err_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            // R1: both addresses are in the window, so an index match means the same word.
            r1.valid       <= bus.dccm_rvalid_in;
            r1.in_range    <= r_in_range;
            r1.bypass      <= bus.dccm_wen & w_in_range & (widx == ridx);
            r1.bypass_data <= bus.dccm_wdata;
            wr_err_q       <= bus.dccm_wen & ~w_in_range;
            // R2: rdata only moves on a response so it holds between pulses.
            rvalid_q <= r1.valid;
            rd_err_q <= r1.valid & ~r1.in_range;
            if (r1.valid) begin
                rdata_q <= !r1.in_range ? '0 :
                           r1.bypass    ? r1.bypass_data : sram_q;
            end
        end
    end

    assign bus.dccm_rdata      = rdata_q;
    assign bus.dccm_rvalid_out = rvalid_q;
    assign bus.dccm_err        = rd_err_q | wr_err_q;

endmodule

// File: tb/tb_dccm_ctrl.sv
// Bench for dccm_ctrl: word model plus response queue, cycle-exact rvalid/err schedule.
module tb_dccm_ctrl;
  import dccm_ctrl_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] LIMIT = 32'h8001_0000;
  localparam int          RD_LAT = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dccm_ctrl_if bus();

  dccm_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  // scoreboard state
  logic [32:0] exp_q[$];
  bit          rv_sched[int];
  bit          err_sched[int];
  logic [31:0] model[int];
  logic [32:0] rsp_exp;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < LIMIT);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // driver: one call = one cycle of request inputs
  task automatic drive(input logic rv, input logic [31:0] ra,
                       input logic we, input logic [31:0] wa, input logic [31:0] wd);
    logic [31:0] d;
    logic        e;
    bus.dccm_rvalid_in = rv;
    bus.dccm_raddr     = ra;
    bus.dccm_wen       = we;
    bus.dccm_waddr     = wa;
    bus.dccm_wdata     = wd;
    if (rv) begin
      if (!in_rng(ra)) begin
        d = 32'h0;
        e = 1'b1;
        err_sched[cyc + RD_LAT] = 1'b1;
      end else begin
        e = 1'b0;
        if (we && in_rng(wa) && word_of(wa) == word_of(ra)) d = wd;
        else if (model.exists(word_of(ra))) d = model[word_of(ra)];
        else d = 'x;
      end
      rv_sched[cyc + RD_LAT] = 1'b1;
      exp_q.push_back({e, d});
    end
    if (we) begin
      if (in_rng(wa)) model[word_of(wa)] = wd;
      else err_sched[cyc + 1] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.dccm_rvalid_in = 1'b0;
    bus.dccm_raddr     = 32'h0;
    bus.dccm_wen       = 1'b0;
    bus.dccm_waddr     = 32'h0;
    bus.dccm_wdata     = 32'h0;
    exp_q.delete();
    rv_sched.delete();
    err_sched.delete();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_in_addr();
    return BASE + 32'h40 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_oor_addr();
    case ($urandom_range(0, 3))
      0: return LIMIT;
      1: return 32'hFFFF_FFFC;
      2: return 32'h0000_0044;
      default: return 32'h7FFF_FFFF;
    endcase
  endfunction

  // monitor: sampled on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      check("rst_rvalid", 64'(bus.dccm_rvalid_out), 64'(0));
      check("rst_rdata", 64'(bus.dccm_rdata), 64'(0));
      check("rst_err", 64'(bus.dccm_err), 64'(0));
    end else begin
      check("rvalid", 64'(bus.dccm_rvalid_out), 64'(rv_sched.exists(cyc)));
      check("err", 64'(bus.dccm_err), 64'(err_sched.exists(cyc)));
      if (bus.dccm_rvalid_out === 1'b1) begin
        check("rsp_pending", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          rsp_exp = exp_q.pop_front();
          check("rdata", 64'(bus.dccm_rdata), 64'(rsp_exp[31:0]));
        end
      end
    end
  end

  initial begin
    do_reset(3);

    // write then read next cycle
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    drive(1'b1, 32'h8000_0010, 1'b0, 32'h0, 32'h0);
    idle(2);

    // same-cycle forward, and a later write that must not leak into an earlier read
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0020, 32'hAAAA_AAAA);
    drive(1'b1, 32'h8000_0020, 1'b1, 32'h8000_0020, 32'h1234_5678);
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0028, 32'hAAAA_AAAA);
    drive(1'b1, 32'h8000_0028, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0028, 32'h5555_5555);
    idle(2);

    // back-to-back reads
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0000, 32'h0000_0000);
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0004, 32'h0000_0004);
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0008, 32'h0000_0008);
    drive(1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h8000_0004, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h8000_0008, 1'b0, 32'h0, 32'h0);
    idle(2);

    // window edges and a dropped out-of-range write aliasing word 0
    drive(1'b1, 32'h7FFF_FFFC, 1'b0, 32'h0, 32'h0);
    drive(1'b1, LIMIT, 1'b0, 32'h0, 32'h0);
    drive(1'b1, LIMIT - 32'h4, 1'b1, LIMIT - 32'h4, 32'h0BAD_F00D);
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
    drive(1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h8000_0013, 1'b0, 32'h0, 32'h0);
    idle(3);

    // random mix over a small preloaded region with occasional out-of-range traffic
    for (int i = 0; i < 8; i++)
      drive(1'b0, 32'h0, 1'b1, BASE + 32'h40 + 32'(4 * i), $urandom);
    for (int i = 0; i < 60; i++) begin
      logic        rv;
      logic        we;
      logic [31:0] ra;
      logic [31:0] wa;
      rv = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? rand_oor_addr() : rand_in_addr();
      wa = ($urandom_range(0, 7) == 0) ? rand_oor_addr() : rand_in_addr();
      drive(rv, ra, we, wa, $urandom);
    end
    idle(3);

    // reset one cycle after a read: its response must never appear
    drive(1'b1, 32'h8000_0010, 1'b0, 32'h0, 32'h0);
    do_reset(1);
    idle(4);
    drive(1'b1, 32'h8000_0010, 1'b0, 32'h0, 32'h0);
    idle(4);

    check("drain", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
